// File: rtl/regression_pkg.sv
// Shared widths and FSM encoding for the regression datapath blocks.
package regression_pkg;

    localparam int unsigned DW_DEF       = 20;
    localparam int unsigned AW_DEF       = 8;
    localparam int unsigned N_POINTS_DEF = 150;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/residual_unit.sv
// Combinational residual e = y - (b_0 + b_1*x) modulo 2^DW, plus saturating |e|.
module residual_unit
    import regression_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] b_0,
    input  logic [DW-1:0] b_1,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] e_c,
    output logic [DW-1:0] abs_e_c
);

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] y_hat;

    always_comb begin
        y_hat = b_0 + b_1 * x;
        e_c   = y - y_hat;
        // -2^(DW-1) has no positive counterpart, so clamp it to the largest positive value
        if (!e_c[DW-1]) begin
            abs_e_c = e_c;
        end else if (e_c == MOST_NEG) begin
            abs_e_c = MOST_POS;
        end else begin
            abs_e_c = DW'(~e_c + 1'b1);
        end
    end

endmodule

// File: rtl/error_checker.sv
// Streams N_POINTS samples from memory, emits per-sample residuals and tracks max |e|.
module error_checker
    import regression_pkg::*;
#(
    parameter int unsigned N_POINTS = N_POINTS_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] b_0,
    input  logic [DW-1:0] b_1,
    input  logic [DW-1:0] x_Bus,
    input  logic [DW-1:0] y_Bus,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] e_Bus,
    output logic          e_valid,
    output logic [DW-1:0] max_abs_error,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_POINTS - 1);

    state_t        state;
    state_t        next_state;
    logic          drain_cnt;
    logic          data_valid;
    logic [DW-1:0] e_c;
    logic [DW-1:0] abs_e_c;

    residual_unit #(.DW(DW)) u_residual (
        .b_0     (b_0),
        .b_1     (b_1),
        .x       (x_Bus),
        .y       (y_Bus),
        .e_c     (e_c),
        .abs_e_c (abs_e_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = READ;
            READ:    if (rd_addr == LAST_ADDR) next_state = DRAIN;
            DRAIN:   if (drain_cnt) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control outputs follow next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            e_Bus         <= '0;
            e_valid       <= 1'b0;
            max_abs_error <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            drain_cnt     <= 1'b0;
            data_valid    <= 1'b0;
        end else begin
            rd_en      <= (next_state == READ);
            busy       <= (next_state == READ) || (next_state == DRAIN);
            done       <= (next_state == DONE);
            drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            data_valid <= rd_en;
            e_valid    <= data_valid;

            if (state == IDLE && start) begin
                rd_addr       <= '0;
                max_abs_error <= '0;
            end else if (state == READ && next_state == READ) begin
                rd_addr <= rd_addr + AW'(1);
            end

            // Memory data for an address arrives one cycle after its rd_en strobe
            if (data_valid) begin
                e_Bus <= e_c;
                if (abs_e_c > max_abs_error) begin
                    max_abs_error <= abs_e_c;
                end
            end
        end
    end

endmodule
